// File: rtl/fpu_pkg.sv
// Shared definitions for the pipelined floating-point add/subtract unit.
// Holds format defaults, the exponent bias helper and stage-record widths.
package fpu_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int GUARD_W   = 2;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Significand record: carry bit, hidden bit, stored fraction, guard bits.
    function automatic int sig_w(input int man_w);
        return man_w + 2 + GUARD_W;
    endfunction

    function automatic int lzc_w(input int man_w);
        return $clog2(sig_w(man_w) + 1);
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fpu_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Three-stage add/subtract for a simplified binary float format (no subnormals,
// infinities or NaNs), truncating toward zero, with valid/ready flow control.
module fpu_addsub_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1+EXP_W+MAN_W-1:0] A,
    input  logic [1+EXP_W+MAN_W-1:0] B,
    input  logic                     op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1+EXP_W+MAN_W-1:0] result,
    output logic                     overFlow,
    output logic                     underFlow
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = sig_w(MAN_W);
    localparam int LZW = lzc_w(MAN_W);

    logic advance;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    logic               sign_a, sign_b, sign_l, sign_s, a_big;
    logic [EXP_W-1:0]   exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [MAN_W-1:0]   frac_a, frac_b, frac_l, frac_s;
    logic [W-2:0]       key_a, key_b;
    logic [SW-1:0]      sig_l, sig_s_full, sig_s;

    assign sign_a = A[W-1];
    assign exp_a  = A[W-2:MAN_W];
    assign frac_a = A[MAN_W-1:0];
    assign sign_b = B[W-1] ^ op;
    assign exp_b  = B[W-2:MAN_W];
    assign frac_b = B[MAN_W-1:0];

    // A zero exponent means zero regardless of fraction, so it ranks lowest.
    assign key_a = (exp_a == '0) ? '0 : {exp_a, frac_a};
    assign key_b = (exp_b == '0) ? '0 : {exp_b, frac_b};
    assign a_big = (key_a >= key_b);

    always_comb begin
        sign_l = a_big ? sign_a : sign_b;
        sign_s = a_big ? sign_b : sign_a;
        exp_l  = a_big ? exp_a  : exp_b;
        exp_s  = a_big ? exp_b  : exp_a;
        frac_l = a_big ? frac_a : frac_b;
        frac_s = a_big ? frac_b : frac_a;

        exp_diff   = exp_l - exp_s;
        sig_l      = (exp_l == '0) ? '0 : {1'b0, 1'b1, frac_l, {GUARD_W{1'b0}}};
        sig_s_full = (exp_s == '0) ? '0 : {1'b0, 1'b1, frac_s, {GUARD_W{1'b0}}};
        sig_s      = (int'(exp_diff) >= MAN_W + 3) ? '0 : (sig_s_full >> exp_diff);
    end

    logic               v1, s1_sign, s1_sub;
    logic [EXP_W-1:0]   s1_exp;
    logic [SW-1:0]      s1_ml, s1_ms;

    logic               v2, s2_sign;
    logic [EXP_W-1:0]   s2_exp;
    logic [SW-1:0]      s2_sum;

    logic [LZW-1:0]     lz;

    fpu_lzc #(
        .W  (SW),
        .CW (LZW)
    ) u_lzc (
        .value (s2_sum),
        .count (lz)
    );

    int                 exp_norm;
    logic [SW-1:0]      norm;
    logic [W-1:0]       s3_result;
    logic               s3_ovf, s3_unf;
    logic               unused_norm_bits;

    // A carry-out gives lz == 0, so one expression covers both shift directions.
    always_comb begin
        exp_norm  = int'(s2_exp) + 1 - int'(lz);
        norm      = (lz == '0) ? (s2_sum >> 1) : (s2_sum << (lz - LZW'(1)));
        s3_result = '0;
        s3_ovf    = 1'b0;
        s3_unf    = 1'b0;
        if (s2_sum != '0) begin
            if (exp_norm >= (1 << EXP_W) - 1) begin
                s3_ovf = 1'b1;
            end else if (exp_norm <= 0) begin
                s3_unf = 1'b1;
            end else begin
                s3_result = {s2_sign, exp_norm[EXP_W-1:0], norm[MAN_W+1:GUARD_W]};
            end
        end
    end

    assign unused_norm_bits = ^{norm[SW-1:MAN_W+2], norm[GUARD_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overFlow  <= 1'b0;
            underFlow <= 1'b0;
        end else if (advance) begin
            v1      <= in_valid;
            s1_sign <= sign_l;
            s1_sub  <= sign_l ^ sign_s;
            s1_exp  <= exp_l;
            s1_ml   <= sig_l;
            s1_ms   <= sig_s;

            v2      <= v1;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_sum  <= s1_sub ? (s1_ml - s1_ms) : (s1_ml + s1_ms);

            out_valid <= v2;
            if (v2) begin
                result    <= s3_result;
                overFlow  <= s3_ovf;
                underFlow <= s3_unf;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed-vector bench for fpu_addsub_pipe in its default single-precision-like format.
module tb_fpu_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overFlow;
    logic        underFlow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    fpu_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overFlow  (overFlow),
        .underFlow (underFlow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Single transaction with out_ready high: result must land exactly three cycles after acceptance.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        A        = v.a;
        B        = v.b;
        op       = v.op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ":early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, ":valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ":result"}, result, v.res);
        checkOutput({tag, ":ovf"}, 32'(overFlow), 32'(v.ovf));
        checkOutput({tag, ":unf"}, 32'(underFlow), 32'(v.unf));
    endtask

    initial begin
        int sent;
        int got;
        int stray;
        bit saw_stall;

        vecs[0]  = '{32'h411C0000, 32'h41948000, 1'b0, 32'h41E28000, 1'b0, 1'b0};
        vecs[1]  = '{32'h411C0000, 32'h41948000, 1'b1, 32'hC10D0000, 1'b0, 1'b0};
        vecs[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{32'h411C0000, 32'h411C0000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[6]  = '{32'hC0200000, 32'h3F800000, 1'b0, 32'hBFC00000, 1'b0, 1'b0};
        vecs[7]  = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0};
        vecs[8]  = '{32'h4D000000, 32'h3F800000, 1'b0, 32'h4D000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0};
        vecs[11] = '{32'h00123456, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};

        // Reset with in_valid asserted: nothing may enter the pipe.
        rst       = 1'b1;
        in_valid  = 1'b1;
        A         = vecs[0].a;
        B         = vecs[0].b;
        op        = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset:valid", 32'(out_valid), 32'd0);
        checkOutput("reset:result", result, 32'd0);
        checkOutput("reset:ovf", 32'(overFlow), 32'd0);
        checkOutput("reset:unf", 32'(underFlow), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("reset:in_ready", 32'(in_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("reset:ignored_input", 32'(stray), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Four back-to-back transactions with the consumer stalled for the first five cycles.
        sent      = 0;
        got       = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                A  = vecs[sent].a;
                B  = vecs[sent].b;
                op = vecs[sent].op;
            end
            #1;
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid) begin
                checkOutput($sformatf("stream%0d:result", got), result, vecs[got].res);
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream:all_received", 32'(got), 32'd4);
        checkOutput("stream:in_ready_dropped", 32'(saw_stall), 32'd1);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("stream:no_duplicate", 32'(stray), 32'd0);

        // Reset with two transactions in flight discards both.
        @(negedge clk);
        A = vecs[0].a; B = vecs[0].b; op = vecs[0].op; in_valid = 1'b1;
        @(negedge clk);
        A = vecs[5].a; B = vecs[5].b; op = vecs[5].op;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset:in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset:result", result, 32'd0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("midreset:discarded", 32'(stray), 32'd0);
        applyStimulus(vecs[6], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
